// File: rtl/ofdm_pkg.sv
// Shared OFDM datapath constants and the unload-sequencer state encoding.
package ofdm_pkg;

  localparam int OFDM_N      = 64;
  localparam int OFDM_W      = 16;
  localparam int OFDM_CP_LEN = 16;
  localparam int OFDM_IDX_W  = $clog2(OFDM_N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    STREAM = 2'd2
  } seq_state_t;

endpackage

// File: rtl/block_sample_mux.sv
// Combinational N:1 selector picking one W-bit sample out of a packed block.
// Shared by the transmit unload path and the receive serial-to-parallel path.
module block_sample_mux #(
  parameter int N = 64,
  parameter int W = 16
) (
  input  logic [N*W-1:0]         block,
  input  logic [$clog2(N)-1:0]   sel,
  output logic [W-1:0]           sample
);

  localparam int SEL_W = $clog2(N);

  always_comb begin
    sample = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        sample = block[k*W +: W];
      end
    end
  end

endmodule

// File: rtl/symbol_p2s_sequencer.sv
// Captures one parallel N-sample block and drains it serially over a valid/ready link.
// Define CP_INSERT_EN to prepend the last CP_LEN samples as a cyclic prefix.
module symbol_p2s_sequencer
  import ofdm_pkg::*;
#(
  parameter int N      = OFDM_N,
  parameter int W      = OFDM_W,
  parameter int CP_LEN = OFDM_CP_LEN
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] in_block,
  input  logic           in_load,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_sof,
  output logic           out_eof,
  output logic           busy
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("symbol_p2s_sequencer: N must be a power of two >= 4");
  end
  if (CP_LEN < 1 || CP_LEN >= N) begin : g_bad_cp
    $error("symbol_p2s_sequencer: CP_LEN must satisfy 1 <= CP_LEN < N");
  end

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N*W-1:0]   block_q;
  logic             capture;
  logic [IDX_W-1:0] sel;
  logic [W-1:0]     mux_sample;

`ifdef CP_INSERT_EN
  localparam logic [IDX_W-1:0] CP_FIRST = IDX_W'(N - CP_LEN);
  logic [IDX_W-1:0] cp_idx_q, cp_idx_d;
`endif

  // The last-sample transfer may coincide with a new load so symbols abut with no bubble.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
`ifdef CP_INSERT_EN
    cp_idx_d = cp_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_load) begin
          capture = 1'b1;
          idx_d   = '0;
`ifdef CP_INSERT_EN
          state_d  = PREFIX;
          cp_idx_d = CP_FIRST;
`else
          state_d = STREAM;
`endif
        end
      end
`ifdef CP_INSERT_EN
      PREFIX: begin
        if (out_ready) begin
          if (cp_idx_q == LAST_IDX) begin
            state_d = STREAM;
            idx_d   = '0;
          end else begin
            cp_idx_d = cp_idx_q + 1'b1;
          end
        end
      end
`endif
      STREAM: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (in_load) begin
              capture = 1'b1;
`ifdef CP_INSERT_EN
              state_d  = PREFIX;
              cp_idx_d = CP_FIRST;
`else
              state_d = STREAM;
`endif
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

`ifdef CP_INSERT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cp_idx_q <= '0;
    end else begin
      cp_idx_q <= cp_idx_d;
    end
  end
`endif

  // The held block is only replaced when a capture is actually accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      block_q <= '0;
    end else if (capture) begin
      block_q <= in_block;
    end
  end

`ifdef CP_INSERT_EN
  assign sel     = (state_q == PREFIX) ? cp_idx_q : idx_q;
  assign out_sof = (state_q == PREFIX) && (cp_idx_q == CP_FIRST);
`else
  assign sel     = idx_q;
  assign out_sof = (state_q == STREAM) && (idx_q == '0);
`endif

  block_sample_mux #(
    .N (N),
    .W (W)
  ) u_mux (
    .block  (block_q),
    .sel    (sel),
    .sample (mux_sample)
  );

  assign out_valid = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign out_eof   = (state_q == STREAM) && (idx_q == LAST_IDX);
  assign in_ready  = (state_q == IDLE) ||
                     ((state_q == STREAM) && (idx_q == LAST_IDX) && out_ready);
  assign out_data  = out_valid ? mux_sample : '0;

endmodule

// File: doc/symbol_p2s_sequencer.md
Name: symbol_p2s_sequencer

Overview:
- Transmit-side unload sequencer for the OFDM datapath.
- Captures one complete N-sample block, presented in parallel, and streams it out one sample per accepted cycle.
- Output uses a valid/ready handshake and carries start-of-symbol and end-of-symbol markers.
- It is the consuming end of the block-load protocol: the upstream loader presents a block and strobes the load; this block drains it serially to the next stage.

Parameters:
- N, 64, samples per OFDM symbol; power of two, minimum 4.
- W, 16, bits per sample.
- CP_LEN, 16, cyclic-prefix length in samples; used only when CP_INSERT_EN is defined; must satisfy 1 <= CP_LEN < N.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_block  input  N*W  parallel block; sample k occupies bits [k*W +: W]; sample 0 is emitted first.
- in_load  input  1  load strobe; the block is captured when in_load && in_ready.
- in_ready  output  1  the sequencer can accept a block this cycle.
- out_data  output  W  current sample.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts; a transfer occurs on out_valid && out_ready.
- out_sof  output  1  high with the first sample of a symbol.
- out_eof  output  1  high with the last sample of a symbol.
- busy  output  1  a block is held and not yet fully drained.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE, idx = 0, block register cleared.
  - out_valid = 0, out_sof = 0, out_eof = 0, busy = 0.
  - in_ready = 1, out_data = 0.
- States:
  - IDLE: no block held; in_ready = 1; out_valid = 0.
  - STREAM: block held; out_valid = 1; out_data = block[idx].
- Transitions:
  - IDLE -> STREAM when in_load. The block is registered and idx = 0. out_valid rises on the next cycle (1-cycle load-to-first-sample latency).
  - In STREAM, each transfer increments idx.
  - At idx == N-1 with a transfer: if in_load is also high this cycle (back-to-back), capture the new block, set idx = 0 and stay in STREAM. Otherwise go to IDLE.
- in_ready = (state == IDLE) || (state == STREAM && idx == N-1 && out_ready). This allows zero-bubble, symbol-after-symbol streaming.
- in_load while in_ready = 0 is ignored; the held block is never overwritten mid-drain.
- out_ready low: idx, out_data and the markers hold steady (AXI-style stall). out_valid never drops once asserted until the last transfer completes.
- out_sof = out_valid && (idx == first emitted index); out_eof = out_valid && (idx == N-1). Both are combinational from registered state and qualify only with out_valid.
- idx is $clog2(N) bits wide and wraps only under the back-to-back rule above; it never exceeds N-1.
- busy = (state == STREAM).
- Reset asserted mid-stream: everything returns to reset values immediately (asynchronously). The partial symbol is discarded and no eof is produced.

Optional Feature:
- Macro: CP_INSERT_EN.
- Defined:
  - Each symbol is emitted as N+CP_LEN samples: block[N-CP_LEN .. N-1] first, then block[0 .. N-1].
  - A PREFIX state is added: capture enters PREFIX with cp_idx = N-CP_LEN; PREFIX -> STREAM (idx = 0) after the transfer at cp_idx == N-1.
  - out_sof marks the first prefix sample; out_eof marks block[N-1].
  - The back-to-back capture re-enters PREFIX.
- Undefined: the PREFIX state and cp_idx logic are absent and CP_LEN is unused; behaviour is exactly as described above.

Decomposition:
- Shared package ofdm_pkg holds:
  - default constants: OFDM_N = 64, OFDM_W = 16, OFDM_CP_LEN = 16;
  - the state enum typedef (IDLE, PREFIX, STREAM);
  - an index-width constant derived via $clog2(OFDM_N).
- One sub-module is natural: block_sample_mux, a combinational N:1 W-bit selector indexed by idx (or cp_idx). It is reused by the receive-side serial-to-parallel path.

Test Plan:
- Reset, then load a block with sample k = k+1, out_ready held 1 -> out_valid rises 1 cycle after the load; outputs 1, 2, ..., 64 on consecutive cycles; sof with 1, eof with 64; in_ready = 0 throughout, then 1; busy clears.
- Same block, out_ready toggled 1,0,1,0... -> each sample is held while stalled; 64 transfers with no duplicates or skips; eof exactly once.
- Second block (sample k = 0x100+k) strobed on the cycle of the sample-64 transfer -> the next cycle outputs 0x100 with sof; no idle bubble between symbols.
- in_load pulsed at idx = 10 with a different block -> ignored; the original samples 11..64 continue unchanged.
- reset deasserted-to-asserted at idx = 30 -> out_valid = 0 and in_ready = 1 immediately, without waiting for a clock; a fresh load restarts at sample 0 with sof.
- CP_INSERT_EN defined, CP_LEN = 16, ramp block -> 80 samples: 49..64 then 1..64; sof on the first 49, eof on the final 64.
